// File: rtl/l2_memory_responder.sv
// L2 backing-store responder for the dcache: LOAD/STORE/CLFLUSH answered after a fixed latency.
// Define XENTRY_L2_STALL_INJECT_EN to stretch each wait by 0..3 extra cycles taken from an LFSR.
package xentry_pkg;
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    STORE   = 2'd1,
    CLFLUSH = 2'd2
  } memory_operation_e;
endpackage

// state   | meaning
// IDLE    | waiting for l2_req_valid, request captured on the accepting edge
// WAIT    | latency counter running down
// RESPOND | one-cycle fulfilled pulse, STORE committed at the edge leaving it
module l2_memory_responder
  import xentry_pkg::*;
#(
  parameter int               XLEN          = 32,
  parameter int               DEPTH_WORDS   = 1024,
  parameter int               LATENCY       = 2,
  parameter logic [XLEN-1:0]  DEFAULT_VALUE = XLEN'(32'hACAB_0012)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [XLEN-1:0]   l2_req_address,
  input  memory_operation_e l2_req_type,
  input  logic              l2_req_valid,
  input  logic [XLEN-1:0]   l2_word_to_store,
  output logic [XLEN-1:0]   l2_fetched_word,
  output logic              l2_req_fulfilled
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] BASE_CNT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_e;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   load_cnt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   req_idx;
  logic [IDX_W-1:0]   resp_idx;
  memory_operation_e  op;
  memory_operation_e  resp_op;
  logic [XLEN-1:0]    store_word;
  logic [XLEN-1:0]    resp_word;
  logic [DEPTH_WORDS-1:0] written;
  logic [XLEN-1:0]    mem [DEPTH_WORDS];
  logic               accept;
  logic               unused_addr_bits;

  // Upper address bits alias onto the same words.
  assign req_idx          = l2_req_address[IDX_W+1:2];
  assign unused_addr_bits = ^{l2_req_address[XLEN-1:IDX_W+2], l2_req_address[1:0]};
  assign accept           = (state == IDLE) && l2_req_valid;

`ifdef XENTRY_L2_STALL_INJECT_EN
  logic [15:0] lfsr;

  assign load_cnt = BASE_CNT + CNT_W'(lfsr[1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else if (accept) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end
`else
  assign load_cnt = BASE_CNT;
`endif

  // In IDLE the response is computed straight from the inputs (LATENCY=1 path).
  always_comb begin
    resp_idx  = idx;
    resp_op   = op;
    resp_word = '0;
    if (state == IDLE) begin
      resp_idx = req_idx;
      resp_op  = l2_req_type;
    end
    if (resp_op == LOAD) begin
      resp_word = written[resp_idx] ? mem[resp_idx] : DEFAULT_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (state == RESPOND && op == STORE) begin
      mem[idx] <= store_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      cnt              <= '0;
      idx              <= '0;
      op               <= LOAD;
      store_word       <= '0;
      written          <= '0;
      l2_fetched_word  <= '0;
      l2_req_fulfilled <= 1'b0;
    end else begin
      l2_req_fulfilled <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx        <= req_idx;
            op         <= l2_req_type;
            store_word <= l2_word_to_store;
            cnt        <= load_cnt;
            if (load_cnt == '0) begin
              state            <= RESPOND;
              l2_req_fulfilled <= 1'b1;
              l2_fetched_word  <= resp_word;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            cnt              <= '0;
            state            <= RESPOND;
            l2_req_fulfilled <= 1'b1;
            l2_fetched_word  <= resp_word;
          end
        end
        RESPOND: begin
          state <= IDLE;
          if (op == STORE) begin
            written[idx] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_memory_responder.sv
// Directed scoreboard bench for l2_memory_responder (default LATENCY=2, DEPTH_WORDS=1024).
module tb_l2_memory_responder;
  import xentry_pkg::*;

  localparam int          LATENCY = 2;
  localparam logic [31:0] DEF     = 32'hACAB_0012;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [31:0]       l2_req_address;
  memory_operation_e l2_req_type;
  logic              l2_req_valid;
  logic [31:0]       l2_word_to_store;
  logic [31:0]       l2_fetched_word;
  logic              l2_req_fulfilled;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int last_pulse_cyc = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model_mem [int];
  bit   [31:0] lat_seen;

  l2_memory_responder dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .l2_req_address   (l2_req_address),
    .l2_req_type      (l2_req_type),
    .l2_req_valid     (l2_req_valid),
    .l2_word_to_store (l2_word_to_store),
    .l2_fetched_word  (l2_fetched_word),
    .l2_req_fulfilled (l2_req_fulfilled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_resp(input memory_operation_e op, input logic [31:0] addr);
    int i;
    i = int'(addr[11:2]);
    if (op == LOAD) return model_mem.exists(i) ? model_mem[i] : DEF;
    return 32'h0;
  endfunction

  task automatic collect(input string tag);
    int k;
    bit seen;
    logic [31:0] exp;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (l2_req_fulfilled) seen = 1'b1;
    end
    check({tag, " seen"}, 32'(seen), 32'd1);
    exp = exp_q.pop_front();
    if (seen) begin
      last_pulse_cyc = cyc;
`ifdef XENTRY_L2_STALL_INJECT_EN
      check({tag, " lat"}, 32'(k >= LATENCY && k <= LATENCY + 3), 32'd1);
      lat_seen[k] = 1'b1;
`else
      check({tag, " lat"}, 32'(k), 32'(LATENCY));
`endif
      check({tag, " data"}, l2_fetched_word, exp);
      @(negedge clk);
      check({tag, " width"}, 32'(l2_req_fulfilled), 32'd0);
      check({tag, " hold"}, l2_fetched_word, exp);
    end
  endtask

  // Caller is at a negedge with the DUT in IDLE.
  task automatic issue(input memory_operation_e op, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit drop, input string tag);
    l2_req_type      = op;
    l2_req_address   = addr;
    l2_word_to_store = wdata;
    l2_req_valid     = 1'b1;
    exp_q.push_back(model_resp(op, addr));
    if (op == STORE) model_mem[int'(addr[11:2])] = wdata;
    @(posedge clk);
    if (drop) begin
      #1;
      l2_req_valid     = 1'b0;
      l2_req_type      = STORE;
      l2_req_address   = $urandom;
      l2_word_to_store = $urandom;
    end
    collect(tag);
  endtask

  initial begin
    logic [31:0] b2b_addr [4];
    int prev, stray, distinct;
    memory_operation_e rop;
    logic [31:0] raddr;

    reset_n          = 1'b0;
    l2_req_valid     = 1'b0;
    l2_req_address   = '0;
    l2_req_type      = LOAD;
    l2_word_to_store = '0;
    lat_seen         = '0;

    repeat (3) @(negedge clk);
    check("rst fulfilled", 32'(l2_req_fulfilled), 32'd0);
    check("rst fetched", l2_fetched_word, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(LOAD,  32'h0000_0040, 32'h0,         1'b1, "load_default");
    issue(STORE, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, "store_beef");
    issue(LOAD,  32'h0000_0102, 32'h0,         1'b1, "load_beef");
    issue(STORE, 32'h0000_1010, 32'h1234_5678, 1'b1, "store_alias");
    issue(LOAD,  32'h0000_0010, 32'h0,         1'b1, "load_alias");
    issue(CLFLUSH, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, "clflush");
    issue(memory_operation_e'(2'b11), 32'h0000_0100, 32'h0BAD_0BAD, 1'b1, "other_type");
    issue(LOAD,  32'h0000_0100, 32'h0,         1'b1, "load_after_flush");

    b2b_addr[0] = 32'h0000_0100;
    b2b_addr[1] = 32'h0000_0010;
    b2b_addr[2] = 32'h0000_0040;
    b2b_addr[3] = 32'h0000_0200;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      issue(LOAD, b2b_addr[i], 32'h0, 1'b0, $sformatf("b2b%0d", i));
      if (i > 0) check($sformatf("b2b%0d spacing", i), 32'(last_pulse_cyc - prev), 32'(LATENCY + 1));
      prev = last_pulse_cyc;
    end
    l2_req_valid = 1'b0;
    @(negedge clk);

    l2_req_type      = STORE;
    l2_req_address   = 32'h0000_0080;
    l2_word_to_store = 32'h5555_AAAA;
    l2_req_valid     = 1'b1;
    @(posedge clk);
    #1 l2_req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset fulfilled", 32'(l2_req_fulfilled), 32'd0);
    check("midreset fetched", l2_fetched_word, 32'd0);
    model_mem.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (l2_req_fulfilled) stray++;
    end
    check("no stray pulse", 32'(stray), 32'd0);
    issue(LOAD, 32'h0000_0080, 32'h0, 1'b1, "load_discarded");
    issue(LOAD, 32'h0000_0100, 32'h0, 1'b1, "load_cleared");

    for (int i = 0; i < 100; i++) begin
      rop   = ($urandom_range(0, 3) == 0) ? STORE : LOAD;
      raddr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      issue(rop, raddr, $urandom, 1'b1, $sformatf("rnd%0d", i));
    end

`ifdef XENTRY_L2_STALL_INJECT_EN
    distinct = 0;
    for (int i = 0; i < 32; i++) if (lat_seen[i]) distinct++;
    check("stall distinct latencies", 32'(distinct >= 2), 32'd1);
`else
    distinct = 0;
    for (int i = 0; i < 32; i++) if (lat_seen[i]) distinct++;
    check("fixed latency unused tracker", 32'(distinct), 32'd0);
`endif
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/l2_memory_responder.md
L2_MEMORY_RESPONDER -- requirements
Module: l2_memory_responder

Interface
REQ-001 Parameter: XLEN, 32, data/address width in bits.
REQ-002 Parameter: DEPTH_WORDS, 1024, backing-store size in XLEN words; power of two.
REQ-003 Parameter: LATENCY, 2, cycles from acceptance edge to fulfilled pulse; legal range 1..15.
REQ-004 Parameter: DEFAULT_VALUE, 32'hACAB_0012, data returned for never-written words.
REQ-005 Port: clk  input  1  single clock, all state on rising edge.
REQ-006 Port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 Port: l2_req_address  input  XLEN  byte address from dcache.
REQ-008 Port: l2_req_type  input  memory_operation_e  LOAD / STORE / CLFLUSH (xentry_pkg).
REQ-009 Port: l2_req_valid  input  1  request present; held with address/type/data until fulfilled.
REQ-010 Port: l2_word_to_store  input  XLEN  store data.
REQ-011 Port: l2_fetched_word  output  XLEN  load data, valid while l2_req_fulfilled high.
REQ-012 Port: l2_req_fulfilled  output  1  one-cycle completion pulse.

Function
REQ-013 Word index SHALL be l2_req_address[$clog2(DEPTH_WORDS)+1:2]; bits [1:0] and bits above the index ignored (aliasing wrap-around).
REQ-014 FSM states SHALL be IDLE, WAIT, RESPOND.
REQ-015 IDLE: on rising edge with l2_req_valid=1, SHALL capture index, type, store data and load counter with LATENCY-1; go to RESPOND if LATENCY=1, else WAIT.
REQ-016 WAIT: counter decrements each cycle; at counter reaching 0, go to RESPOND.
REQ-017 RESPOND: l2_req_fulfilled SHALL be 1 for exactly this one cycle; next state IDLE.
REQ-018 Fulfilled pulse SHALL occur exactly LATENCY cycles after the accepting edge (no stall injection).
REQ-019 LOAD: in RESPOND, l2_fetched_word SHALL equal stored word if its written bit is set, else DEFAULT_VALUE.
REQ-020 STORE: word and its written bit SHALL be committed at the edge ending RESPOND; a LOAD accepted afterward returns the new value.
REQ-021 CLFLUSH or any other type: fulfilled normally, no memory change, l2_fetched_word=0.
REQ-022 Inputs SHALL be ignored outside IDLE; deasserting l2_req_valid after acceptance does not cancel the request.
REQ-023 l2_req_valid still high in IDLE after RESPOND SHALL start a new request (back-to-back, one IDLE cycle between pulses).
REQ-024 l2_fetched_word SHALL hold its last value outside RESPOND.

Reset
REQ-025 reset_n low SHALL immediately force IDLE, l2_req_fulfilled=0, l2_fetched_word=0, counter=0, all written bits=0.
REQ-026 Reset mid-request SHALL discard the request; pending STORE not committed; no fulfilled pulse after release.
REQ-027 Word storage array SHALL NOT be reset (written bits alone define contents).
REQ-028 First acceptance SHALL be no earlier than the first rising edge after reset_n deasserts.

Configuration
REQ-029 Macro XENTRY_L2_STALL_INJECT_EN SHALL, when defined, add a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advancing once per accepted request.
REQ-030 With the macro: WAIT duration extended by LFSR[1:0] (0..3) extra cycles, sampled at acceptance.
REQ-031 Without the macro: no LFSR, latency exactly LATENCY per REQ-018.

Verification
REQ-032 Reset release, LOAD addr 0x0000_0040, LATENCY=2 -> fulfilled 2 cycles after acceptance, fetched 0xACAB_0012.
REQ-033 STORE 0xDEAD_BEEF @0x0000_0100 then LOAD @0x0000_0102 -> fetched 0xDEAD_BEEF; each pulse exactly one cycle.
REQ-034 DEPTH_WORDS=1024: STORE 0x1234_5678 @0x0000_1010, LOAD @0x0000_0010 -> 0x1234_5678 (alias).
REQ-035 valid held high with 4 successive addresses changed after each pulse -> 4 pulses, spacing LATENCY+1 cycles, data per address.
REQ-036 reset_n low during WAIT of STORE 0x5555_AAAA @0x80, then LOAD @0x80 -> no stray pulse, fetched 0xACAB_0012.
REQ-037 XENTRY_L2_STALL_INJECT_EN defined, 100 LOADs -> every latency in 2..5, at least two distinct values, data correct.
